// File: rtl/mlp_core_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mlp_core_param                                                           |
// | Two-layer inference sequencer: binary pixels -> hidden -> output -> argmax.|
// | Optional abort input when MLP_CORE_ABORT_EN is defined.                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mlp_core_param #(
  parameter int N_IN   = 784,
  parameter int N_HID  = 32,
  parameter int N_OUT  = 10,
  parameter int DW     = 8,
  parameter int ACC_W  = 26,
  parameter int LUT_AW = 11,
  parameter int SHIFT  = 7,
  localparam int IN_AW  = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int WH_AW  = (N_HID * N_IN > 1) ? $clog2(N_HID * N_IN) : 1,
  localparam int WO_AW  = (N_OUT * N_HID > 1) ? $clog2(N_OUT * N_HID) : 1,
  localparam int OUT_AW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef MLP_CORE_ABORT_EN
  input  logic              abort,
`endif
  input  logic              start,
  output logic [IN_AW-1:0]  in_addr,
  input  logic              in_q,
  output logic [WH_AW-1:0]  wh_addr,
  input  logic [DW-1:0]     wh_q,
  output logic [WO_AW-1:0]  wo_addr,
  input  logic [DW-1:0]     wo_q,
  output logic [LUT_AW-1:0] lut_addr,
  input  logic [DW-1:0]     lut_q,
  output logic              busy,
  output logic              done,
  output logic [OUT_AW-1:0] digit,
  output logic [DW-1:0]     max_val
);

  localparam int HID_AW = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam int K_N    = (N_IN > N_HID) ? N_IN : N_HID;
  localparam int K_W    = (K_N > 1) ? $clog2(K_N) : 1;
  localparam int U_N    = (N_HID > N_OUT) ? N_HID : N_OUT;
  localparam int U_W    = (U_N > 1) ? $clog2(U_N) : 1;

  localparam logic signed [ACC_W-1:0] c_sat_hi = ACC_W'((64'd1 << (LUT_AW - 1)) - 64'd1);
  localparam logic signed [ACC_W-1:0] c_sat_lo = ~c_sat_hi;
  localparam logic [DW-1:0]           c_pix_on = {1'b0, {(DW-1){1'b1}}};

  typedef enum logic [3:0] {
    S_IDLE, S_H_MAC, S_H_DRAIN, S_H_LUT, S_H_WRITE,
    S_O_MAC, S_O_DRAIN, S_O_LUT, S_O_WRITE, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [K_W-1:0]           r_k;      // MAC element / drain counter
  logic [U_W-1:0]           r_unit;   // hidden unit, then output unit
  logic                     r_dv, r_pv;
  logic signed [ACC_W-1:0]  r_prod, r_acc;
  logic [DW-1:0]            r_hid_q;
  logic [DW-1:0]            r_hidden [N_HID];
  logic [DW-1:0]            r_best_val;
  logic [OUT_AW-1:0]        r_best_idx;

  logic                     w_abort, w_kill, w_out_layer, w_take;
  logic [31:0]              w_unit_ext, w_k_ext;
  logic signed [DW:0]       w_opa;
  logic signed [DW-1:0]     w_opb;
  logic signed [2*DW:0]     w_prod;
  logic signed [ACC_W-1:0]  w_shift;
  logic [LUT_AW-1:0]        w_sat, w_lut_addr;
  logic [DW-1:0]            w_best_val;
  logic [OUT_AW-1:0]        w_best_idx;

`ifdef MLP_CORE_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif
  assign w_kill = w_abort && (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE:    if (start && !w_abort) w_next = S_H_MAC;
      S_H_MAC:   begin busy = 1'b1; if (r_k == K_W'(N_IN - 1)) w_next = S_H_DRAIN; end
      S_H_DRAIN: begin busy = 1'b1; if (r_k == K_W'(1)) w_next = S_H_LUT; end
      S_H_LUT:   begin busy = 1'b1; w_next = S_H_WRITE; end
      S_H_WRITE: begin
        busy   = 1'b1;
        w_next = (r_unit == U_W'(N_HID - 1)) ? S_O_MAC : S_H_MAC;
      end
      S_O_MAC:   begin busy = 1'b1; if (r_k == K_W'(N_HID - 1)) w_next = S_O_DRAIN; end
      S_O_DRAIN: begin busy = 1'b1; if (r_k == K_W'(1)) w_next = S_O_LUT; end
      S_O_LUT:   begin busy = 1'b1; w_next = S_O_WRITE; end
      S_O_WRITE: begin
        busy   = 1'b1;
        w_next = (r_unit == U_W'(N_OUT - 1)) ? S_DONE : S_O_MAC;
      end
      S_DONE:    begin done = 1'b1; w_next = S_IDLE; end
      default:   w_next = S_IDLE;
    endcase
    if (w_kill) begin
      w_next = S_IDLE;
      done   = 1'b0;
    end
  end

  assign w_unit_ext = 32'(r_unit);
  assign w_k_ext    = 32'(r_k);
  assign in_addr    = (r_state == S_H_MAC) ? IN_AW'(r_k) : '0;
  assign wh_addr    = (r_state == S_H_MAC) ? WH_AW'(w_unit_ext * N_IN + w_k_ext) : '0;
  assign wo_addr    = (r_state == S_O_MAC) ? WO_AW'(w_unit_ext * N_HID + w_k_ext) : '0;
  assign lut_addr   = (r_state == S_H_LUT || r_state == S_O_LUT) ? w_lut_addr : '0;

  // Data arrives one cycle after its address, so the layer is judged from the following state.
  assign w_out_layer = (r_state == S_O_MAC) || (r_state == S_O_DRAIN);

  always_comb begin
    if (w_out_layer) begin
      w_opa = {1'b0, r_hid_q};
      w_opb = $signed(wo_q);
    end else begin
      w_opa = in_q ? {1'b0, c_pix_on} : '0;
      w_opb = $signed(wh_q);
    end
    w_prod = (2*DW+1)'(w_opa) * (2*DW+1)'(w_opb);
  end

  always_comb begin
    w_shift = r_acc >>> SHIFT;
    if (w_shift > c_sat_hi)      w_sat = LUT_AW'(c_sat_hi);
    else if (w_shift < c_sat_lo) w_sat = LUT_AW'(c_sat_lo);
    else                         w_sat = LUT_AW'(w_shift);
    w_lut_addr = {~w_sat[LUT_AW-1], w_sat[LUT_AW-2:0]};
  end

  // Unit 0 always seeds the running max; strict compare keeps the lowest index on ties.
  assign w_take     = (r_unit == '0) || (lut_q > r_best_val);
  assign w_best_val = w_take ? lut_q : r_best_val;
  assign w_best_idx = w_take ? OUT_AW'(r_unit) : r_best_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k        <= '0;
      r_unit     <= '0;
      r_dv       <= 1'b0;
      r_pv       <= 1'b0;
      r_prod     <= '0;
      r_acc      <= '0;
      r_hid_q    <= '0;
      r_best_val <= '0;
      r_best_idx <= '0;
      digit      <= '0;
      max_val    <= '0;
      for (int i = 0; i < N_HID; i++) r_hidden[i] <= '0;
    end else begin
      if (w_kill || w_next != r_state) r_k <= '0;
      else if (r_state inside {S_H_MAC, S_H_DRAIN, S_O_MAC, S_O_DRAIN}) r_k <= r_k + K_W'(1);

      if (w_kill) r_unit <= '0;
      else if (r_state == S_H_WRITE)
        r_unit <= (r_unit == U_W'(N_HID - 1)) ? '0 : r_unit + U_W'(1);
      else if (r_state == S_O_WRITE)
        r_unit <= (r_unit == U_W'(N_OUT - 1)) ? '0 : r_unit + U_W'(1);

      r_dv   <= !w_kill && (r_state == S_H_MAC || r_state == S_O_MAC);
      r_pv   <= !w_kill && r_dv;
      r_prod <= ACC_W'(w_prod);
      if (r_state == S_O_MAC) r_hid_q <= r_hidden[HID_AW'(r_k)];

      if (w_kill || r_state == S_H_WRITE || r_state == S_O_WRITE) r_acc <= '0;
      else if (r_pv) r_acc <= r_acc + r_prod;

      if (r_state == S_H_WRITE) r_hidden[HID_AW'(r_unit)] <= lut_q;

      if (r_state == S_O_WRITE && !w_kill) begin
        r_best_val <= w_best_val;
        r_best_idx <= w_best_idx;
        if (r_unit == U_W'(N_OUT - 1)) begin
          digit   <= w_best_idx;
          max_val <= w_best_val;
        end
      end
    end
  end

endmodule
`default_nettype wire
